// File: rtl/fetch_redirect_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_redirect_unit_if
// Bundles every fetch-side signal of fetch_redirect_unit except clk/rst.
//   master : the fetch unit (drives PCF, the IF/ID fields, flushes and debug)
//   slave  : the surrounding hazard unit / imem / decode / execute logic
// Signals:
//   RedirectE, PCTargetE   execute-stage redirect request and target
//   StallF, StallD         hazard-unit stall requests
//   InstrF                 imem read data at PCF (combinational)
//   PCF                    fetch address
//   InstrD, PCD, PCPlus4D, ValidD   IF/ID register contents
//   FlushD, FlushE, MisalignE       combinational redirect side effects
//   FetchState             fetch FSM state (debug)
//   RedirectCount, StallCycles      only with FETCH_REDIRECT_STATS_EN defined
// ---------------------------------------------------------------------------
interface fetch_redirect_unit_if #(
   parameter int WIDTH = 32
);
   logic             RedirectE;
   logic [WIDTH-1:0] PCTargetE;
   logic             StallF;
   logic             StallD;
   logic [31:0]      InstrF;
   logic [WIDTH-1:0] PCF;
   logic [31:0]      InstrD;
   logic [WIDTH-1:0] PCD;
   logic [WIDTH-1:0] PCPlus4D;
   logic             ValidD;
   logic             FlushD;
   logic             FlushE;
   logic             MisalignE;
   logic [1:0]       FetchState;
`ifdef FETCH_REDIRECT_STATS_EN
   logic [31:0]      RedirectCount;
   logic [31:0]      StallCycles;
`endif

   modport master (
      input  RedirectE, PCTargetE, StallF, StallD, InstrF,
      output PCF, InstrD, PCD, PCPlus4D, ValidD,
             FlushD, FlushE, MisalignE, FetchState
`ifdef FETCH_REDIRECT_STATS_EN
      , output RedirectCount, StallCycles
`endif
   );

   modport slave (
      output RedirectE, PCTargetE, StallF, StallD, InstrF,
      input  PCF, InstrD, PCD, PCPlus4D, ValidD,
             FlushD, FlushE, MisalignE, FetchState
`ifdef FETCH_REDIRECT_STATS_EN
      , input RedirectCount, StallCycles
`endif
   );
endinterface

// File: rtl/fetch_redirect_unit.sv
// ---------------------------------------------------------------------------
// fetch_redirect_unit
// Owns the fetch PC (PCF) and the IF/ID pipeline register. Consumes the
// execute-stage redirect, applies stall/flush priority and squashes the
// wrong-path instruction held in decode.
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous active-high reset, overrides every other input
//   bus  - fetch_redirect_unit_if.master (redirect, stalls, imem, IF/ID,
//          flushes, misalign flag, FSM state)
// Parameters:
//   WIDTH        - PC / datapath width
//   RESET_VECTOR - PCF after reset
//   NOP_INSTR    - instruction placed in decode on flush/reset
// Optional build macro:
//   FETCH_REDIRECT_STATS_EN - adds saturating RedirectCount / StallCycles
// ---------------------------------------------------------------------------
module fetch_redirect_unit #(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter logic [31:0]      NOP_INSTR    = 32'h0000_0013
) (
   input logic                  clk,
   input logic                  rst,
   fetch_redirect_unit_if.master bus
);

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STALL = 2'd2,
      ST_REDIR = 2'd3
   } state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] pcf_reg, pcf_next;
   logic [31:0]      instr_d_reg, instr_d_next;
   logic [WIDTH-1:0] pc_d_reg, pc_d_next;
   logic [WIDTH-1:0] pc_plus4_d_reg, pc_plus4_d_next;
   logic             valid_d_reg, valid_d_next;
   logic [WIDTH-1:0] pcf_plus4;

   // Wraps modulo 2^WIDTH with no overflow indication.
   assign pcf_plus4 = pcf_reg + WIDTH'(4);

   // ---------------------------------------------------------------------
   // Next-state / next-value logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_next      = state_reg;
      pcf_next        = pcf_reg;
      instr_d_next    = instr_d_reg;
      pc_d_next       = pc_d_reg;
      pc_plus4_d_next = pc_plus4_d_reg;
      valid_d_next    = valid_d_reg;

      // All four states share the same exits: BOOT and REDIR are one-cycle
      // states only because their successor is re-decided every cycle.
      case (state_reg)
         ST_BOOT, ST_RUN, ST_STALL, ST_REDIR: begin
            if (bus.RedirectE)   state_next = ST_REDIR;
            else if (bus.StallF) state_next = ST_STALL;
            else                 state_next = ST_RUN;
         end
         default: state_next = ST_RUN;
      endcase

      // PCF: redirect > StallF > increment. Target is word-aligned by
      // dropping its low bits; MisalignE reports the event.
      if (bus.RedirectE)
         pcf_next = {bus.PCTargetE[WIDTH-1:2], 2'b00};
      else if (!bus.StallF)
         pcf_next = pcf_plus4;

      // IF/ID: flush > StallD > load. The first load after reset carries
      // whatever imem returned during BOOT, so it is marked as a bubble.
      if (bus.RedirectE) begin
         instr_d_next    = NOP_INSTR;
         pc_d_next       = '0;
         pc_plus4_d_next = '0;
         valid_d_next    = 1'b0;
      end else if (!bus.StallD) begin
         instr_d_next    = bus.InstrF;
         pc_d_next       = pcf_reg;
         pc_plus4_d_next = pcf_plus4;
         valid_d_next    = (state_reg != ST_BOOT);
      end
   end

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_BOOT;
         pcf_reg        <= RESET_VECTOR;
         instr_d_reg    <= NOP_INSTR;
         pc_d_reg       <= '0;
         pc_plus4_d_reg <= '0;
         valid_d_reg    <= 1'b0;
      end else begin
         state_reg      <= state_next;
         pcf_reg        <= pcf_next;
         instr_d_reg    <= instr_d_next;
         pc_d_reg       <= pc_d_next;
         pc_plus4_d_reg <= pc_plus4_d_next;
         valid_d_reg    <= valid_d_next;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs. InstrF reaches outputs only through instr_d_reg.
   // ---------------------------------------------------------------------
   assign bus.PCF        = pcf_reg;
   assign bus.InstrD     = instr_d_reg;
   assign bus.PCD        = pc_d_reg;
   assign bus.PCPlus4D   = pc_plus4_d_reg;
   assign bus.ValidD     = valid_d_reg;
   assign bus.FlushD     = bus.RedirectE;
   assign bus.FlushE     = bus.RedirectE;
   assign bus.MisalignE  = bus.RedirectE & (bus.PCTargetE[1:0] != 2'b00);
   assign bus.FetchState = state_reg;

`ifdef FETCH_REDIRECT_STATS_EN
   // Saturating event counters; a stalled cycle only counts when no
   // redirect overrides it.
   logic [31:0] redirect_cnt_reg;
   logic [31:0] stall_cnt_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         redirect_cnt_reg <= '0;
         stall_cnt_reg    <= '0;
      end else begin
         if (bus.RedirectE && (redirect_cnt_reg != 32'hFFFF_FFFF))
            redirect_cnt_reg <= redirect_cnt_reg + 32'd1;
         if (bus.StallF && !bus.RedirectE && (stall_cnt_reg != 32'hFFFF_FFFF))
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
   end

   assign bus.RedirectCount = redirect_cnt_reg;
   assign bus.StallCycles   = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_redirect_unit
// Directed bench for fetch_redirect_unit. imem is modelled as a PC-indexed
// ROM (InstrF = 32'hA500_0000 ^ PCF). Inputs change 1 ns after the rising
// edge; outputs are checked 2 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_fetch_redirect_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk;
   logic rst;
   int   errors;
   int   checks;
   int   cyc;

   fetch_redirect_unit_if #(.WIDTH(32)) bus ();

   fetch_redirect_unit #(
      .WIDTH(32),
      .RESET_VECTOR(32'h0000_0000),
      .NOP_INSTR(NOP)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   assign bus.InstrF = 32'hA500_0000 ^ bus.PCF;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs may be changed on return, outputs settle 1 ns
   // later.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      $display("cyc %0d rst=%b redir=%b tgt=%h sf=%b sd=%b | PCF=%h PCD=%h InstrD=%h V=%b st=%0d",
               cyc, rst, bus.RedirectE, bus.PCTargetE, bus.StallF, bus.StallD,
               bus.PCF, bus.PCD, bus.InstrD, bus.ValidD, bus.FetchState);
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      cyc    = 0;
      rst    = 1'b1;
      bus.RedirectE = 1'b0;
      bus.PCTargetE = 32'h0;
      bus.StallF    = 1'b0;
      bus.StallD    = 1'b0;

      // ---- reset state ----
      step();
      step();
      settle();
      check_val("rst_pcf",   bus.PCF,        32'h0);
      check_val("rst_instr", bus.InstrD,     NOP);
      check_val("rst_pcd",   bus.PCD,        32'h0);
      check_val("rst_pc4d",  bus.PCPlus4D,   32'h0);
      check_val("rst_valid", {31'd0, bus.ValidD}, 32'd0);
      check_val("rst_state", {30'd0, bus.FetchState}, 32'd0);
`ifdef FETCH_REDIRECT_STATS_EN
      check_val("rst_rcnt", bus.RedirectCount, 32'd0);
      check_val("rst_scnt", bus.StallCycles,   32'd0);
`endif
      rst = 1'b0;

      // ---- free run: first load after BOOT is a bubble ----
      step(); settle();
      check_val("run1_pcf",   bus.PCF, 32'h4);
      check_val("run1_valid", {31'd0, bus.ValidD}, 32'd0);
      check_val("run1_state", {30'd0, bus.FetchState}, 32'd1);
      check_val("run1_instr", bus.InstrD, 32'hA500_0000);
      step(); settle();
      check_val("run2_pcf",   bus.PCF, 32'h8);
      check_val("run2_pcd",   bus.PCD, 32'h4);
      check_val("run2_pc4d",  bus.PCPlus4D, 32'h8);
      check_val("run2_instr", bus.InstrD, 32'hA500_0004);
      check_val("run2_valid", {31'd0, bus.ValidD}, 32'd1);
      step(); settle();
      check_val("run3_pcf", bus.PCF, 32'hC);
      check_val("run3_pcd", bus.PCD, 32'h8);
      step(); settle();
      check_val("run4_pcf", bus.PCF, 32'h10);
      check_val("run4_pcd", bus.PCD, 32'hC);

      // ---- taken redirect at PCF=0x10 to 0x40 ----
      bus.RedirectE = 1'b1;
      bus.PCTargetE = 32'h40;
      settle();
      check_val("redir_flushd", {31'd0, bus.FlushD}, 32'd1);
      check_val("redir_flushe", {31'd0, bus.FlushE}, 32'd1);
      check_val("redir_misal",  {31'd0, bus.MisalignE}, 32'd0);
      step();
      bus.RedirectE = 1'b0;
      settle();
      check_val("redir_pcf",   bus.PCF, 32'h40);
      check_val("redir_instr", bus.InstrD, NOP);
      check_val("redir_pcd",   bus.PCD, 32'h0);
      check_val("redir_valid", {31'd0, bus.ValidD}, 32'd0);
      check_val("redir_state", {30'd0, bus.FetchState}, 32'd3);
      check_val("redir_flush_off", {31'd0, bus.FlushD}, 32'd0);
      step(); settle();
      check_val("tgt_pcd",   bus.PCD, 32'h40);
      check_val("tgt_instr", bus.InstrD, 32'hA500_0040);
      check_val("tgt_valid", {31'd0, bus.ValidD}, 32'd1);
      check_val("tgt_pcf",   bus.PCF, 32'h44);
      check_val("tgt_state", {30'd0, bus.FetchState}, 32'd1);

      // ---- StallF+StallD for 3 cycles at PCF=0x44 ----
      bus.StallF = 1'b1;
      bus.StallD = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(); settle();
         check_val("stall_pcf",   bus.PCF, 32'h44);
         check_val("stall_pcd",   bus.PCD, 32'h40);
         check_val("stall_instr", bus.InstrD, 32'hA500_0040);
         check_val("stall_state", {30'd0, bus.FetchState}, 32'd2);
      end
      bus.StallF = 1'b0;
      bus.StallD = 1'b0;
      step(); settle();
      check_val("rel_pcf",   bus.PCF, 32'h48);
      check_val("rel_pcd",   bus.PCD, 32'h44);
      check_val("rel_state", {30'd0, bus.FetchState}, 32'd1);

      // ---- redirect overrides stall ----
      bus.StallF    = 1'b1;
      bus.StallD    = 1'b1;
      bus.RedirectE = 1'b1;
      bus.PCTargetE = 32'h100;
      step();
      bus.StallF    = 1'b0;
      bus.StallD    = 1'b0;
      bus.RedirectE = 1'b0;
      settle();
      check_val("rs_pcf",   bus.PCF, 32'h100);
      check_val("rs_instr", bus.InstrD, NOP);
      check_val("rs_valid", {31'd0, bus.ValidD}, 32'd0);
      check_val("rs_state", {30'd0, bus.FetchState}, 32'd3);

      // ---- misaligned target ----
      bus.PCTargetE = 32'h22;
      settle();
      check_val("misal_noredir", {31'd0, bus.MisalignE}, 32'd0);
      bus.RedirectE = 1'b1;
      settle();
      check_val("misal_flag", {31'd0, bus.MisalignE}, 32'd1);
      step();
      bus.RedirectE = 1'b0;
      settle();
      check_val("misal_pcf", bus.PCF, 32'h20);

      // ---- PC wrap at top of address space ----
      bus.RedirectE = 1'b1;
      bus.PCTargetE = 32'hFFFF_FFFC;
      step();
      bus.RedirectE = 1'b0;
      settle();
      check_val("wrap_top", bus.PCF, 32'hFFFF_FFFC);
      step(); settle();
      check_val("wrap_pcf",  bus.PCF, 32'h0);
      check_val("wrap_pcd",  bus.PCD, 32'hFFFF_FFFC);
      check_val("wrap_pc4d", bus.PCPlus4D, 32'h0);

      // ---- StallD alone: PCF advances, IF/ID holds ----
      bus.StallD = 1'b1;
      step();
      bus.StallD = 1'b0;
      settle();
      check_val("sd_pcf", bus.PCF, 32'h4);
      check_val("sd_pcd", bus.PCD, 32'hFFFF_FFFC);

      // ---- reset during STALL ----
      bus.StallF = 1'b1;
      step(); settle();
      check_val("pre_rst_state", {30'd0, bus.FetchState}, 32'd2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.StallF = 1'b0;
      settle();
      check_val("rst_stall_pcf",   bus.PCF, 32'h0);
      check_val("rst_stall_valid", {31'd0, bus.ValidD}, 32'd0);
      check_val("rst_stall_state", {30'd0, bus.FetchState}, 32'd0);

      // ---- reset during REDIR, with redirect still asserted ----
      bus.RedirectE = 1'b1;
      bus.PCTargetE = 32'h300;
      step(); settle();
      check_val("pre_rst2_state", {30'd0, bus.FetchState}, 32'd3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.RedirectE = 1'b0;
      settle();
      check_val("rst_redir_pcf",   bus.PCF, 32'h0);
      check_val("rst_redir_valid", {31'd0, bus.ValidD}, 32'd0);
      check_val("rst_redir_state", {30'd0, bus.FetchState}, 32'd0);
`ifdef FETCH_REDIRECT_STATS_EN
      check_val("rst2_rcnt", bus.RedirectCount, 32'd0);
      check_val("rst2_scnt", bus.StallCycles,   32'd0);
`endif

      // ---- BOOT -> REDIR, then a second redirect ----
      bus.RedirectE = 1'b1;
      bus.PCTargetE = 32'h80;
      step();
      bus.PCTargetE = 32'h200;
      settle();
      check_val("boot_redir_state", {30'd0, bus.FetchState}, 32'd3);
      check_val("boot_redir_pcf",   bus.PCF, 32'h80);
      step();
      bus.RedirectE = 1'b0;
      settle();
      check_val("b2b_state", {30'd0, bus.FetchState}, 32'd3);
      check_val("b2b_pcf",   bus.PCF, 32'h200);
      step(); settle();
      check_val("b2b_pcd",   bus.PCD, 32'h200);
      check_val("b2b_valid", {31'd0, bus.ValidD}, 32'd1);
`ifdef FETCH_REDIRECT_STATS_EN
      check_val("rcnt_two", bus.RedirectCount, 32'd2);
      bus.StallF = 1'b1;
      step();
      step();
      bus.StallF = 1'b0;
      settle();
      check_val("scnt_two", bus.StallCycles, 32'd2);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Hard time bound so the run always terminates.
   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
